// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction scorer.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DELAY,
        STIMULUS,
        RELEASE,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int DEF_TICK_DIV     = 2000;
    localparam int DEF_NO_ROUNDS    = 10;
    localparam int DEF_MIN_DELAY_MS = 500;
    localparam int DEF_LIMIT_MS     = 400;
    localparam int DEF_TIMEOUT_MS   = 1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, clearable.
module ms_tick_gen #(
    parameter int TICK_DIV = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reaction_scorer.sv
// Reflex test FSM with LFSR delays and scoring.
// Optional: FALSE_START_PENALTY_EN makes a false start cost one point.
module reaction_scorer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int NO_ROUNDS    = DEF_NO_ROUNDS,
    parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
    parameter int LIMIT_MS     = DEF_LIMIT_MS,
    parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       brake_btn,
    output logic       stimulus,
    output logic       busy,
    output logic [3:0] round_idx,
    output logic [3:0] score,
    output logic       over,
    output logic [9:0] last_time_ms
);
    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [9:0] ms_cnt_q, ms_cnt_d;
    logic [9:0] delay_q, delay_d;
    logic [3:0] round_q, round_d;
    logic [3:0] score_q, score_d;
    logic [9:0] last_q, last_d;
    logic       stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       over_q, over_d;
    logic       tick, clr;

    assign clr = (state_d != state_q);

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (tick && ms_cnt_q != 10'h3FF) ms_cnt_d = ms_cnt_q + 10'd1;
        if (clr) ms_cnt_d = '0;
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_next(lfsr_q);
        delay_d = delay_q;
        round_d = round_q;
        score_d = score_q;
        last_d  = last_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        over_d  = over_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = WAIT_DELAY;
                busy_d  = 1'b1;
                delay_d = 10'(MIN_DELAY_MS) + 10'(lfsr_q);
            end
            WAIT_DELAY: if (brake_btn) begin
                state_d = RELEASE;
                round_d = round_q + 4'd1;
`ifdef FALSE_START_PENALTY_EN
                if (score_q != 4'd0) score_d = score_q - 4'd1;
`else
                score_d = score_q;
`endif
            end else if (ms_cnt_q == delay_q) begin
                state_d = STIMULUS;
                stim_d  = 1'b1;
            end
            STIMULUS: if (brake_btn) begin
                // A press in the timeout cycle still gets judged.
                state_d = RELEASE;
                stim_d  = 1'b0;
                round_d = round_q + 4'd1;
                if (ms_cnt_q < 10'(LIMIT_MS)) begin
                    last_d = ms_cnt_q;
                    if (score_q != 4'hF) score_d = score_q + 4'd1;
                end
            end else if (ms_cnt_q == 10'(TIMEOUT_MS)) begin
                state_d = RELEASE;
                stim_d  = 1'b0;
                round_d = round_q + 4'd1;
            end
            RELEASE: if (!brake_btn) begin
                if (round_q == 4'(NO_ROUNDS)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    over_d  = 1'b1;
                end else begin
                    state_d = WAIT_DELAY;
                    delay_d = 10'(MIN_DELAY_MS) + 10'(lfsr_q);
                end
            end
            DONE: if (start) begin
                state_d = WAIT_DELAY;
                busy_d  = 1'b1;
                over_d  = 1'b0;
                score_d = '0;
                round_d = '0;
                delay_d = 10'(MIN_DELAY_MS) + 10'(lfsr_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            ms_cnt_q <= '0;
            delay_q  <= '0;
            round_q  <= '0;
            score_q  <= '0;
            last_q   <= '0;
            stim_q   <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            ms_cnt_q <= ms_cnt_d;
            delay_q  <= delay_d;
            round_q  <= round_d;
            score_q  <= score_d;
            last_q   <= last_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
        end
    end

    assign stimulus     = stim_q;
    assign busy         = busy_q;
    assign round_idx    = round_q;
    assign score        = score_q;
    assign over         = over_q;
    assign last_time_ms = last_q;

endmodule

// File: doc/reaction_scorer.md
Name: reaction_scorer

Overview:
- Producer of the `score`/`over` pair consumed by the two-digit score display on DE10-LITE.
- Runs a reflex test of NO_ROUNDS rounds. Each round waits a pseudo-random delay, then raises `stimulus` (emergency event LED) and times the driver's brake press.
- A press within LIMIT_MS earns one point.
- After the last round, `score` is frozen and `over` is asserted.

Parameters:
- TICK_DIV, 2000, clk cycles per 1 ms tick (2 MHz clk).
- NO_ROUNDS, 10, rounds per test (1..15).
- MIN_DELAY_MS, 500, minimum wait before stimulus.
- LIMIT_MS, 400, max reaction time (ms) that scores a point.
- TIMEOUT_MS, 1000, stimulus duration before the round counts as a miss (TIMEOUT_MS > LIMIT_MS).

Ports:
- clk, input, 1, system clock (2 MHz).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a test.
- brake_btn, input, 1, brake button; already synchronized and debounced, 1 = pressed.
- stimulus, output, 1, event LED; 1 = react now.
- busy, output, 1, test in progress.
- round_idx, output, 4, rounds completed in the current test.
- score, output, 4, points earned (0..NO_ROUNDS).
- over, output, 1, test finished; `score` is final.
- last_time_ms, output, 10, reaction time of the last scoring press, in ms.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high; clock and reset ports are `clk` and `rst`.
  - `rst` overrides everything, including mid-round: state=IDLE, stimulus=0, busy=0, round_idx=0, score=0, over=0, last_time_ms=0, lfsr=8'hA5, ms_cnt=0, tick prescaler=0.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and pulses `tick` when it equals TICK_DIV-1.
  - `ms_cnt` (10 bit, saturating at 1023) increments on `tick`.
  - Both the prescaler and `ms_cnt` clear on every state transition.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, advances every clk.
  - On WAIT_DELAY entry: delay_ms = MIN_DELAY_MS + lfsr[7:0].
- FSM states: IDLE, WAIT_DELAY, STIMULUS, RELEASE, DONE.
  - IDLE: on `start` -> WAIT_DELAY. Score and round_idx are already 0.
  - WAIT_DELAY:
    - busy=1, stimulus=0.
    - brake_btn=1 (false start): round_idx+1, no point, -> RELEASE.
    - Otherwise, when ms_cnt==delay_ms -> STIMULUS.
  - STIMULUS:
    - stimulus=1, registered and asserted the cycle after entry.
    - brake_btn=1 with ms_cnt<LIMIT_MS: score+1, last_time_ms=ms_cnt, -> RELEASE.
    - brake_btn=1 with ms_cnt>=LIMIT_MS: no point, -> RELEASE.
    - ms_cnt==TIMEOUT_MS without a press: miss, -> RELEASE.
    - Every exit increments round_idx.
    - If press and timeout occur in the same cycle, the press wins and is judged against LIMIT_MS.
  - RELEASE:
    - stimulus=0.
    - Waits for brake_btn=0, so a held button cannot trigger the next round.
    - Then: round_idx==NO_ROUNDS -> DONE; otherwise -> WAIT_DELAY.
  - DONE:
    - busy=0, over=1, score and last_time_ms held.
    - On `start`: score=0, round_idx=0, over=0 on the next edge, -> WAIT_DELAY.
- `start` while busy is ignored.
- `score` saturates at 15 and never wraps; it cannot exceed NO_ROUNDS in normal operation.
- `over` stays high from DONE entry until the next `start` or `rst`.

Optional Feature:
- Macro: FALSE_START_PENALTY_EN.
- Defined: a false start in WAIT_DELAY decrements `score`, with a floor of 0 (no underflow).
- Undefined: a false start only consumes the round; `score` is unchanged.

Decomposition:
- Shared package `reaction_pkg`:
  - State enum (IDLE..DONE).
  - LFSR seed 8'hA5 and tap constants.
  - Default timing constants for the 2 MHz clock.
- Sub-module `ms_tick_gen` (parameter TICK_DIV; ports clk, rst, clr, tick) holds the prescaler.
- The FSM, LFSR and score logic stay in `reaction_scorer`.

Test Plan (all scenarios use TICK_DIV=4, MIN_DELAY_MS=2, LIMIT_MS=5, TIMEOUT_MS=20, NO_ROUNDS=3):
- Reset mid-STIMULUS -> next cycle stimulus=0, score=0, round_idx=0, over=0, busy=0.
- start, then press 3 ms after stimulus rises in every round -> score=3, last_time_ms=3, over=1 after round 3.
- start, never press -> each stimulus lasts 20 ms then drops; final score=0, over=1, round_idx=3.
- Press at ms 7 (>=LIMIT) in round 1, ms 2 in rounds 2 and 3 -> score=2, last_time_ms=2.
- Press during WAIT_DELAY in round 1 -> no stimulus that round, round_idx=1, score unchanged (0); with FALSE_START_PENALTY_EN defined, score stays 0 (floor check).
- Button held through RELEASE for 10 ms -> no new WAIT_DELAY until release; start pulse while busy -> ignored; start in DONE -> score clears to 0, over drops next cycle.
